// File: rtl/control_unit.sv
// Multi-cycle control unit: Moore FSM sequencing fetch, decode, load, store, add and sub.
// Optional macro CU_HALT_EN routes opcode 0101 to a HALT state left only by reset.
module control_unit #(
  parameter int unsigned D_AW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     IR,
  output logic            PC_clr,
  output logic            PC_up,
  output logic            IR_ld,
  output logic [D_AW-1:0] D_addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic [2:0]      ALU_s0,
  output logic [3:0]      out_state
);

  typedef enum logic [3:0] {
    StInit   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StNoop   = 4'd3,
    StLoadA  = 4'd4,
    StLoadB  = 4'd5,
    StStore  = 4'd6,
    StAdd    = 4'd7,
    StSub    = 4'd8,
    StHalt   = 4'd9
  } state_e;

  state_e state_q, state_d;

  logic [3:0]      opcode;
  logic [D_AW-1:0] load_addr;
  logic [D_AW-1:0] store_addr;

  assign opcode     = IR[15:12];
  assign load_addr  = D_AW'(IR[11:4]);
  assign store_addr = D_AW'(IR[7:0]);
  assign out_state  = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:   state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (opcode)
          4'h0:    state_d = StNoop;
          4'h1:    state_d = StStore;
          4'h2:    state_d = StLoadA;
          4'h3:    state_d = StAdd;
          4'h4:    state_d = StSub;
`ifdef CU_HALT_EN
          4'h5:    state_d = StHalt;
`endif
          default: state_d = StNoop;
        endcase
      end
      StLoadA:  state_d = StLoadB;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs depend only on the registered state and the held instruction.
  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = 4'h0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = 4'h0;
    RF_Rb_addr = 4'h0;
    ALU_s0     = 3'b000;
    unique case (state_q)
      StInit:  PC_clr = 1'b1;
      StFetch: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      StDecode: begin
        // Early address/register presentation so read data lands in the next state.
        if (opcode == 4'h2) begin
          D_addr = load_addr;
        end else if (opcode == 4'h1) begin
          D_addr = store_addr;
        end
        RF_Ra_addr = IR[11:8];
        RF_Rb_addr = IR[7:4];
      end
      StLoadA: D_addr = load_addr;
      StLoadB: begin
        D_addr    = load_addr;
        RF_s      = 1'b1;
        RF_W_en   = 1'b1;
        RF_W_addr = IR[3:0];
      end
      StStore: begin
        D_wr       = 1'b1;
        D_addr     = store_addr;
        RF_Ra_addr = IR[11:8];
      end
      StAdd, StSub: begin
        RF_Ra_addr = IR[11:8];
        RF_Rb_addr = IR[7:4];
        RF_W_addr  = IR[3:0];
        RF_W_en    = 1'b1;
        ALU_s0     = (state_q == StAdd) ? 3'b001 : 3'b010;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: compares every output as one packed vector per cycle.
// Honors CU_HALT_EN for the opcode 0101 scenario.
module tb_control_unit;

  logic        clk;
  logic        reset;
  logic [15:0] IR;
  logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, out_state;
  logic [2:0]  ALU_s0;

  int passed = 0;
  int total  = 0;

  logic [32:0] outs;
  logic [32:0] exp_v;

  control_unit #(.D_AW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .IR         (IR),
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IR_ld      (IR_ld),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .out_state  (out_state)
  );

  assign outs = {PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
                 RF_Ra_addr, RF_Rb_addr, ALU_s0, out_state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] mk(input logic pc_clr, input logic pc_up, input logic ir_ld,
                                     input logic [7:0] d_addr, input logic d_wr,
                                     input logic rf_s, input logic [3:0] w_addr,
                                     input logic w_en, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [2:0] alu,
                                     input logic [3:0] st);
    return {pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, w_addr, w_en, ra, rb, alu, st};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    IR    = 16'h0000;
    step();
    exp_v = mk(1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 4'd0);
    total++;
    if (outs !== exp_v) $display("FAIL reset_cycle1 got %h exp %h", outs, exp_v);
    else passed++;
    step();
    total++;
    if (outs !== exp_v) $display("FAIL reset_held got %h exp %h", outs, exp_v);
    else passed++;
    reset = 1'b0;
    step();
    exp_v = mk(0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 4'd1);
    total++;
    if (outs !== exp_v) $display("FAIL reset_fetch got %h exp %h", outs, exp_v);
    else passed++;
    step();
    exp_v = mk(0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 4'd2);
    total++;
    if (outs !== exp_v) $display("FAIL reset_decode got %h exp %h", outs, exp_v);
    else passed++;
    step();
    exp_v = mk(0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 4'd3);
    total++;
    if (outs !== exp_v) $display("FAIL noop_state got %h exp %h", outs, exp_v);
    else passed++;
    step();
    total++;
    if (out_state !== 4'd1) $display("FAIL noop_to_fetch got %0d exp 1", out_state);
    else passed++;
  endtask

  task automatic test_unknown_opcode();
    IR = 16'hF000;
    step();
    step();
    exp_v = mk(0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 4'd3);
    total++;
    if (outs !== exp_v) $display("FAIL unknown_op_noop got %h exp %h", outs, exp_v);
    else passed++;
    step();
    total++;
    if (out_state !== 4'd1) $display("FAIL unknown_op_fetch got %0d exp 1", out_state);
    else passed++;
  endtask

  task automatic test_load();
    IR = 16'h2A53;
    step();
    exp_v = mk(0, 0, 0, 8'hA5, 0, 0, 4'h0, 0, 4'hA, 4'h5, 3'b000, 4'd2);
    total++;
    if (outs !== exp_v) $display("FAIL load_decode got %h exp %h", outs, exp_v);
    else passed++;
    step();
    exp_v = mk(0, 0, 0, 8'hA5, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 4'd4);
    total++;
    if (outs !== exp_v) $display("FAIL load_a got %h exp %h", outs, exp_v);
    else passed++;
    step();
    exp_v = mk(0, 0, 0, 8'hA5, 0, 1, 4'h3, 1, 4'h0, 4'h0, 3'b000, 4'd5);
    total++;
    if (outs !== exp_v) $display("FAIL load_b got %h exp %h", outs, exp_v);
    else passed++;
    step();
    exp_v = mk(0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 4'd1);
    total++;
    if (outs !== exp_v) $display("FAIL load_to_fetch got %h exp %h", outs, exp_v);
    else passed++;
  endtask

  task automatic test_alu(input logic [15:0] instr, input logic [2:0] alu, input logic [3:0] st);
    IR = instr;
    step();
    exp_v = mk(0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h1, 4'h2, 3'b000, 4'd2);
    total++;
    if (outs !== exp_v) $display("FAIL alu_decode %h got %h exp %h", instr, outs, exp_v);
    else passed++;
    step();
    exp_v = mk(0, 0, 0, 8'h00, 0, 0, 4'h4, 1, 4'h1, 4'h2, alu, st);
    total++;
    if (outs !== exp_v) $display("FAIL alu_exec %h got %h exp %h", instr, outs, exp_v);
    else passed++;
    step();
    total++;
    if (out_state !== 4'd1) $display("FAIL alu_to_fetch %h got %0d exp 1", instr, out_state);
    else passed++;
  endtask

  task automatic test_store();
    IR = 16'h17F0;
    step();
    exp_v = mk(0, 0, 0, 8'hF0, 0, 0, 4'h0, 0, 4'h7, 4'hF, 3'b000, 4'd2);
    total++;
    if (outs !== exp_v) $display("FAIL store_decode got %h exp %h", outs, exp_v);
    else passed++;
    step();
    exp_v = mk(0, 0, 0, 8'hF0, 1, 0, 4'h0, 0, 4'h7, 4'h0, 3'b000, 4'd6);
    total++;
    if (outs !== exp_v) $display("FAIL store_exec got %h exp %h", outs, exp_v);
    else passed++;
    step();
    exp_v = mk(0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 4'd1);
    total++;
    if (outs !== exp_v) $display("FAIL store_to_fetch got %h exp %h", outs, exp_v);
    else passed++;
  endtask

  task automatic test_halt();
    IR = 16'h5000;
    step();
    total++;
    if (out_state !== 4'd2) $display("FAIL halt_decode got %0d exp 2", out_state);
    else passed++;
`ifdef CU_HALT_EN
    exp_v = mk(0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 4'd9);
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (outs !== exp_v) $display("FAIL halt_hold cyc%0d got %h exp %h", i, outs, exp_v);
      else passed++;
    end
    reset = 1'b1;
    step();
    total++;
    if (out_state !== 4'd0) $display("FAIL halt_reset got %0d exp 0", out_state);
    else passed++;
    reset = 1'b0;
    step();
`else
    step();
    exp_v = mk(0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 4'd3);
    total++;
    if (outs !== exp_v) $display("FAIL halt_as_noop got %h exp %h", outs, exp_v);
    else passed++;
    step();
`endif
    total++;
    if (out_state !== 4'd1) $display("FAIL halt_exit_fetch got %0d exp 1", out_state);
    else passed++;
  endtask

  task automatic test_reset_mid_load();
    IR = 16'h2A53;
    step();
    step();
    total++;
    if (out_state !== 4'd4) $display("FAIL midload_in_load_a got %0d exp 4", out_state);
    else passed++;
    reset = 1'b1;
    step();
    exp_v = mk(1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 4'd0);
    total++;
    if (outs !== exp_v) $display("FAIL midload_reset got %h exp %h", outs, exp_v);
    else passed++;
    reset = 1'b0;
    step();
    total++;
    if (out_state !== 4'd1 || RF_W_en !== 1'b0) begin
      $display("FAIL midload_recover got state %0d wen %b exp state 1 wen 0", out_state, RF_W_en);
    end else passed++;
  endtask

  initial begin
    reset = 1'b1;
    IR    = 16'h0000;
    test_reset();
    test_unknown_opcode();
    test_load();
    test_alu(16'h3124, 3'b001, 4'd7);
    test_alu(16'h4124, 3'b010, 4'd8);
    test_store();
    test_halt();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter D_AW, default 8, the data-memory address width carried in the instruction.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 SHALL have port IR, input, 16, the instruction held by the instruction register; [15:12] is the opcode.
REQ-005 SHALL have port PC_clr, output, 1, which clears the program counter.
REQ-006 SHALL have port PC_up, output, 1, which increments the program counter.
REQ-007 SHALL have port IR_ld, output, 1, the load enable of the instruction register.
REQ-008 SHALL have port D_addr, output, D_AW, the data-memory address.
REQ-009 SHALL have port D_wr, output, 1, the data-memory write enable.
REQ-010 SHALL have port RF_s, output, 1, the register-file write-source select: 1 = memory, 0 = ALU.
REQ-011 SHALL have port RF_W_addr, output, 4, the register-file write address.
REQ-012 SHALL have port RF_W_en, output, 1, the register-file write enable.
REQ-013 SHALL have port RF_Ra_addr, output, 4, register-file read port A address.
REQ-014 SHALL have port RF_Rb_addr, output, 4, register-file read port B address.
REQ-015 SHALL have port ALU_s0, output, 3, the ALU function select: 000 = pass A, 001 = add, 010 = sub.
REQ-016 SHALL have port out_state, output, 4, the current state encoding for debug.

Function
REQ-017 SHALL implement a Moore FSM with states INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
REQ-018 SHALL make every output registered-state-decoded; unlisted outputs are 0 in every state.
REQ-019 SHALL, in INIT, assert PC_clr and then go to FETCH.
REQ-020 SHALL, in FETCH, assert IR_ld and PC_up and then go to DECODE; IR is valid from DECODE onward.
REQ-021 SHALL, in DECODE, branch on IR[15:12]: 0000 to NOOP, 0001 to STORE, 0010 to LOAD_A, 0011 to ADD, 0100 to SUB, 0101 to HALT; every other opcode goes to NOOP.
REQ-022 SHALL, in DECODE, drive D_addr = IR[11:4] for LOAD and IR[7:0] for STORE, and drive RF_Ra_addr and RF_Rb_addr from the IR, so that read data is available in the next state.
REQ-023 SHALL, in LOAD_A, set D_addr = IR[11:4], then go to LOAD_B (one-cycle memory read latency).
REQ-024 SHALL, in LOAD_B, set RF_s=1, RF_W_en=1, RF_W_addr = IR[3:0] and D_addr = IR[11:4], then go to FETCH.
REQ-025 SHALL, in STORE, set D_wr=1, D_addr = IR[7:0], RF_Ra_addr = IR[11:8] and ALU_s0=000, then go to FETCH.
REQ-026 SHALL, in ADD and SUB, set RF_Ra_addr = IR[11:8], RF_Rb_addr = IR[7:4], RF_W_addr = IR[3:0], RF_W_en=1 and RF_s=0, with ALU_s0 = 001 for ADD and 010 for SUB, then go to FETCH.
REQ-027 SHALL, in NOOP, assert no outputs and go to FETCH.
REQ-028 SHALL issue one instruction per FETCH at the following latencies: NOOP 3 cycles, STORE/ADD/SUB 3 cycles, LOAD 4 cycles, each measured from FETCH to the next FETCH.
REQ-029 SHALL never assert D_wr and RF_W_en in the same cycle.

Reset
REQ-030 SHALL, while reset=1 at a clock edge, enter INIT regardless of state, including mid-LOAD and HALT.
REQ-031 SHALL, in the cycle after reset, present INIT outputs: PC_clr=1, all other outputs 0, out_state=0.
REQ-032 SHALL, when reset is held for multiple cycles, remain in INIT with PC_clr asserted.

Configuration
REQ-033 SHALL, when CU_HALT_EN is defined, send opcode 0101 to HALT, which has no outputs asserted, holds itself, and is left only by reset.
REQ-034 SHALL, when CU_HALT_EN is undefined, treat opcode 0101 as NOOP; the HALT state is then unreachable.

Verification
REQ-035 SHALL be verified by: reset for 2 cycles, then release -> out_state sequence 0,1,2 and PC_clr=1 only in INIT.
REQ-036 SHALL be verified by: IR=16'h2A53 (LOAD) -> LOAD_A then LOAD_B, with D_addr=8'hA5, RF_W_addr=3, RF_s=1 and RF_W_en=1 in LOAD_B only.
REQ-037 SHALL be verified by: IR=16'h3124 (ADD) -> ADD state with Ra=1, Rb=2, W_addr=4, ALU_s0=001 and RF_W_en=1; 16'h4124 gives ALU_s0=010.
REQ-038 SHALL be verified by: IR=16'h17F0 (STORE) -> D_wr=1, D_addr=8'hF0 and Ra=7 for exactly one cycle, then FETCH.
REQ-039 SHALL be verified by: IR=16'h5000 -> with CU_HALT_EN, out_state stays 9 for 10 cycles; without it, returns to FETCH after 3 cycles.
REQ-040 SHALL be verified by: reset asserted during LOAD_A -> INIT next cycle, and no RF_W_en pulse occurs.
